ifmap_window_sequencer: RTL and testbench
=========================================

Name: ifmap_window_sequencer

Overview:
- Sequencer directly upstream of the stride step counter in the conv datapath.
- Walks a 1-D sliding window over the IFmap scratchpad and issues one read address per filter tap to the PE through a valid/ready handshake.
- After each completed window it advances the window base by the stride and emits the next_stride pulse that drives the stride step counter's count_en.

Parameters:
- ADDR_W, 5, width of IFmap address, filter_size and ifmap_len (matches the stride step counter WIDTH).
- STRIDE_W, 3, width of the stride input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle request to begin a pass; honoured only in IDLE.
- filter_size  in  ADDR_W  taps per window (F).
- stride  in  STRIDE_W  window step (S); 0 is treated as 1.
- ifmap_len  in  ADDR_W  IFmap words in this pass (L).
- ifmap_avail  in  ADDR_W+1  count of IFmap words already written to the scratchpad.
- rd_addr  out  ADDR_W  IFmap read address, equal to base+k.
- filt_idx  out  ADDR_W  current tap index k.
- rd_valid  out  1  rd_addr/filt_idx are valid.
- rd_ready  in  1  PE accepts the current tap.
- last_tap  out  1  high with rd_valid when k==F-1.
- next_stride  out  1  one-cycle pulse per completed window.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  one-cycle pulse at end of pass.

Behaviour:
- Reset (rst=0, async): state=IDLE; base, k and the config registers are cleared; every output is 0.
- States: IDLE, LOAD, READ, ADVANCE, DONE.
- IDLE -> LOAD on start.
- LOAD (1 cycle):
  - Latches F, S_eff=max(S,1) and L; sets base=0, k=0.
  - If F==0 or F>L, goes to DONE; no reads and no next_stride.
  - Otherwise goes to READ.
- READ:
  - rd_valid = (base+k < ifmap_avail).
  - While not available, rd_valid=0 (stall); this is not an error.
  - A transfer is rd_valid && rd_ready in the same cycle.
  - On transfer with k<F-1: k <= k+1.
  - On transfer with k==F-1: go to ADVANCE.
  - Once rd_valid is asserted, rd_addr, filt_idx, last_tap and rd_valid stay stable until the transfer.
  - ifmap_avail never decreases during a pass.
- ADVANCE (1 cycle):
  - next_stride=1; base <= base+S_eff; k <= 0.
  - If base+S_eff+F > L, go to DONE; otherwise go to READ.
- DONE (1 cycle): done=1, then IDLE.
- Arithmetic: all base/limit sums are computed at ADDR_W+2 bits, with no wrap-around.
- Window count is floor((L-F)/S_eff)+1; read count is that times F.
- Latency:
  - start to first rd_valid is 2 cycles when data is already available.
  - There are no bubbles between taps inside a window under rd_ready=1.
  - There is one bubble (ADVANCE) between windows.
- start during busy is ignored.
- Config inputs are sampled only in LOAD.
- Reset mid-pass aborts immediately; no done pulse and no partial next_stride.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=0, LOAD=1, READ=2, ADVANCE=3, DONE=4, 3-bit);
  - default ADDR_W/STRIDE_W constants, shared with the stride step counter.
- One sub-module, window_tap_counter: the k counter with clear, enable and terminal flag (k==F-1).

Test Plan:
- Baseline: L=8, F=3, S=2, ifmap_avail=8, rd_ready=1.
  - Reads at addresses 0,1,2, 2,3,4, 4,5,6.
  - last_tap on the 3rd, 6th and 9th reads.
  - 3 next_stride pulses, then done; busy drops the cycle after done.
- Backpressure: same config, rd_ready toggling 1/0.
  - Exactly 9 transfers in the same address order.
  - rd_addr held stable on every stalled cycle.
- Availability stall: L=8, F=3, S=1, ifmap_avail starting at 2 and incremented every 4 cycles.
  - rd_valid stays low at addr 2 until avail=3.
  - 6 windows and 18 reads total.
- Degenerate configs:
  - F=0, or F=9 with L=8: LOAD -> DONE, zero rd_valid, zero next_stride, done 2 cycles after start.
  - S=0 with L=4, F=2: behaves as S=1, giving 3 windows.
- Reset mid-op: rst=0 during the 2nd window, READ.
  - All outputs 0 immediately.
  - After release and a new start, a full baseline pass repeats correctly.
- Busy start: start pulses while busy.
  - Ignored, with no change to the address sequence or pulse count.

Source files
------------

// File: rtl/ifmap_window_sequencer_pkg.sv
// Shared constants and state encoding for the IFmap window sequencer.
package ifmap_window_sequencer_pkg;

    // Defaults shared with the stride step counter.
    localparam int unsigned ADDR_W_DEF   = 5;
    localparam int unsigned STRIDE_W_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_READ    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/ifmap_window_sequencer_tap_counter.sv
// Filter tap index counter: clear, enable and terminal flag at k == f-1.
module window_tap_counter
    import ifmap_window_sequencer_pkg::*;
#(
    parameter int unsigned W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] f,
    output logic [W-1:0] k,
    output logic [W-1:0] k_nxt_c,
    output logic         last_c
);

    // Next tap index; clear wins over enable.
    always_comb begin
        k_nxt_c = k;
        if (clr) begin
            k_nxt_c = '0;
        end else if (en) begin
            k_nxt_c = k + W'(1);
        end
    end

    assign last_c = (f != '0) && (k == f - W'(1));

    // Tap index register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
        end else begin
            k <= k_nxt_c;
        end
    end

endmodule

// File: rtl/ifmap_window_sequencer.sv
// Walks a 1-D sliding window over the IFmap scratchpad, one read per tap,
// and pulses next_stride after each completed window.
module ifmap_window_sequencer
    import ifmap_window_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned STRIDE_W = STRIDE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   filter_size,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [ADDR_W-1:0]   ifmap_len,
    input  logic [ADDR_W:0]     ifmap_avail,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic [ADDR_W-1:0]   filt_idx,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic                last_tap,
    output logic                next_stride,
    output logic                busy,
    output logic                done
);

    // Base/limit sums are kept wide enough that they never wrap.
    localparam int unsigned SUM_W = ADDR_W + 2;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   f_q;
    logic [ADDR_W-1:0]   l_q;
    logic [STRIDE_W-1:0] s_q;
    logic [SUM_W-1:0]    base_q;
    logic [SUM_W-1:0]    base_nxt;
    logic                k_clr;
    logic                k_en;
    logic                k_last;
    logic [ADDR_W-1:0]   k;
    logic [ADDR_W-1:0]   k_nxt;
    logic [ADDR_W-1:0]   f_nxt;
    logic [SUM_W-1:0]    addr_nxt;
    logic                valid_nxt;
    logic                last_nxt;
    logic                xfer;

    assign xfer = rd_valid && rd_ready;

    window_tap_counter #(.W(ADDR_W)) u_tap (
        .clk     (clk),
        .rst     (rst),
        .clr     (k_clr),
        .en      (k_en),
        .f       (f_q),
        .k       (k),
        .k_nxt_c (k_nxt),
        .last_c  (k_last)
    );

    assign filt_idx = k;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, tap counter control and window base update.
    always_comb begin
        state_nxt = state;
        k_clr     = 1'b0;
        k_en      = 1'b0;
        base_nxt  = base_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                k_clr    = 1'b1;
                base_nxt = '0;
                if ((filter_size == '0) || (filter_size > ifmap_len)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (xfer) begin
                    if (k_last) begin
                        state_nxt = ST_ADVANCE;
                    end else begin
                        k_en = 1'b1;
                    end
                end
            end
            ST_ADVANCE: begin
                k_clr    = 1'b1;
                base_nxt = base_q + SUM_W'(s_q);
                if ((base_nxt + SUM_W'(f_q)) > SUM_W'(l_q)) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = ST_READ;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead so they leave the block registered.
    assign f_nxt     = (state == ST_LOAD) ? filter_size : f_q;
    assign addr_nxt  = base_nxt + SUM_W'(k_nxt);
    assign valid_nxt = (state_nxt == ST_READ) && (addr_nxt < SUM_W'(ifmap_avail));
    assign last_nxt  = valid_nxt && (k_nxt == f_nxt - ADDR_W'(1));

    // Config capture, window base and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_q         <= '0;
            s_q         <= '0;
            l_q         <= '0;
            base_q      <= '0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            last_tap    <= 1'b0;
            next_stride <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (state == ST_LOAD) begin
                f_q <= filter_size;
                s_q <= (stride == '0) ? STRIDE_W'(1) : stride;
                l_q <= ifmap_len;
            end
            base_q      <= base_nxt;
            rd_addr     <= ADDR_W'(addr_nxt);
            rd_valid    <= valid_nxt;
            last_tap    <= last_nxt;
            next_stride <= (state_nxt == ST_ADVANCE);
            busy        <= (state_nxt != ST_IDLE);
            done        <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ifmap_window_sequencer.sv
// Randomized self-checking bench for ifmap_window_sequencer against a
// window/tap list model built from F, S and L.
module tb_ifmap_window_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] filter_size;
    logic [2:0] stride;
    logic [4:0] ifmap_len;
    logic [5:0] ifmap_avail;
    logic [4:0] rd_addr;
    logic [4:0] filt_idx;
    logic       rd_valid;
    logic       rd_ready;
    logic       last_tap;
    logic       next_stride;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    ifmap_window_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .filter_size (filter_size),
        .stride      (stride),
        .ifmap_len   (ifmap_len),
        .ifmap_avail (ifmap_avail),
        .rd_addr     (rd_addr),
        .filt_idx    (filt_idx),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .last_tap    (last_tap),
        .next_stride (next_stride),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pass; called and returns at posedge+1 with the DUT idle.
    // ready_mode: 0 always ready, 1 toggling, 2 random. avail_mode: 0 all present, 1 trickle.
    task automatic run_pass(input int f, input int s, input int l,
                            input int ready_mode, input int avail_mode, input int busy_starts);
        int exp_addr[$];
        int exp_k[$];
        int exp_last[$];
        int seff, windows, cyc, done_cyc, first_valid;
        int xfers, strides, dones, avail, stall_addr;
        logic stall_prev;

        seff    = (s == 0) ? 1 : s;
        windows = (f == 0 || f > l) ? 0 : (l - f) / seff + 1;
        for (int w = 0; w < windows; w++) begin
            for (int t = 0; t < f; t++) begin
                exp_addr.push_back(w * seff + t);
                exp_k.push_back(t);
                exp_last.push_back((t == f - 1) ? 1 : 0);
            end
        end

        filter_size = 5'(f);
        stride      = 3'(s);
        ifmap_len   = 5'(l);
        avail       = (avail_mode != 0) ? 2 : l;
        ifmap_avail = 6'(avail);
        rd_ready    = 1'b1;
        start       = 1'b1;
        cyc = 0; done_cyc = -1; first_valid = -1;
        xfers = 0; strides = 0; dones = 0; stall_prev = 1'b0; stall_addr = 0;

        forever begin
            @(negedge clk);
            if (rd_valid && first_valid < 0) first_valid = cyc;
            if (stall_prev) begin
                check("stall_valid_held", rd_valid, 1);
                check("stall_addr_held", rd_addr, stall_addr);
            end
            if (rd_valid) check("addr_available", (32'(rd_addr) < 32'(ifmap_avail)), 1);
            if (rd_valid && rd_ready) begin
                xfers++;
                if (exp_addr.size() > 0) begin
                    check("rd_addr", rd_addr, exp_addr.pop_front());
                    check("filt_idx", filt_idx, exp_k.pop_front());
                    check("last_tap", last_tap, exp_last.pop_front());
                end else begin
                    check("extra_transfer", 1, 0);
                end
            end
            stall_prev = rd_valid && !rd_ready;
            stall_addr = rd_addr;
            if (next_stride) strides++;
            if (done) begin
                dones++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check("busy_with_done", busy, 1);
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("busy_after_done", busy, 0);
                break;
            end
            if (cyc > 1000) begin
                check("pass_timeout", 0, 1);
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
            start = (busy_starts != 0 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (ready_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (avail_mode != 0 && (cyc % 4) == 0 && avail < 63) avail++;
            ifmap_avail = 6'(avail);
        end

        check("transfer_count", xfers, windows * f);
        check("next_stride_count", strides, windows);
        check("done_count", dones, 1);
        check("reads_left", exp_addr.size(), 0);
        if (windows == 0) begin
            check("degenerate_done_latency", done_cyc, 2);
            check("degenerate_no_valid", first_valid, -1);
        end else if (avail_mode == 0) begin
            check("first_valid_latency", first_valid, 2);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int strides_seen;
        logic reached;

        rst = 1'b0; start = 1'b0; filter_size = '0; stride = '0;
        ifmap_len = '0; ifmap_avail = '0; rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rd_addr, filt_idx, rd_valid, last_tap, next_stride, busy, done}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_pass(3, 2, 8, 0, 0, 0);   // baseline
        run_pass(3, 2, 8, 1, 0, 0);   // backpressure
        run_pass(3, 1, 8, 0, 1, 0);   // availability stall
        run_pass(0, 2, 8, 0, 0, 0);   // F = 0
        run_pass(9, 2, 8, 0, 0, 0);   // F > L
        run_pass(2, 0, 4, 0, 0, 0);   // S = 0 acts as 1

        // Reset during READ of the second window.
        filter_size = 5'd3; stride = 3'd2; ifmap_len = 5'd8; ifmap_avail = 6'd8;
        rd_ready = 1'b1; start = 1'b1;
        strides_seen = 0; reached = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (next_stride) strides_seen++;
            if (strides_seen == 1 && rd_valid) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("reached_second_window", reached, 1);
        rst = 1'b0;
        #1;
        check("midpass_reset_outputs", {rd_addr, filt_idx, rd_valid, last_tap, next_stride, busy, done}, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held_reset_outputs", {rd_addr, filt_idx, rd_valid, last_tap, next_stride, busy, done}, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_pass(3, 2, 8, 0, 0, 0);   // full baseline after reset

        run_pass(3, 2, 8, 2, 0, 1);   // start pulses while busy

        for (int n = 0; n < 20; n++) begin
            run_pass(int'($urandom_range(0, 10)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
